if_fetch_queue: RTL and testbench

Parametrised successor to the single-PC fetch stage. It decouples instruction fetch from decode through an N-entry prefetch queue with valid/ready output handshake. It issues word-aligned fetches to a synchronous 1-cycle-latency instruction memory under a credit scheme, so memory data can never be lost. Branch/jump redirect flushes the queue and drops any in-flight response. It sits between the PC/instruction memory and the IF/ID register.

---
 rtl/if_fetch_queue_if.sv | 28 ++
 rtl/if_fetch_queue.sv | 83 ++++++++
 tb/tb_if_fetch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: instruction memory port, redirect input and decode-side handshake.
// The master modport belongs to the fetch queue; the slave modport is the surrounding core/memory.
interface if_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                      redirect;
    logic [XLEN-1:0]           redirect_pc;
    logic                      imem_en;
    logic [XLEN-3:0]           imem_addr;
    logic [XLEN-1:0]           imem_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_instr;
    logic [XLEN-1:0]           out_pc;
    logic [XLEN-1:0]           out_pcplus4;
    logic [$clog2(DEPTH):0]    q_count;

    modport master (
        input  redirect, redirect_pc, imem_rdata, out_ready,
        output imem_en, imem_addr, out_valid, out_instr, out_pc, out_pcplus4, q_count
    );

    modport slave (
        output redirect, redirect_pc, imem_rdata, out_ready,
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_pcplus4, q_count
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with an N-entry prefetch queue between a 1-cycle instruction memory
// and decode; credit-based issue guarantees every returning word has a free slot.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_queue_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;
    logic            unused_pc_lsbs;

    // Slots already promised: stored entries plus the outstanding fetch, minus what decode takes now.
    assign occupancy     = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign bus.out_valid = rst_n && (count != '0) && !bus.redirect;
    assign pop           = bus.out_valid && bus.out_ready;
    assign issue         = rst_n && !bus.redirect && (occupancy < DEPTH_C);
    assign push          = inflight && !bus.redirect;

    assign bus.imem_en     = issue;
    assign bus.imem_addr   = fetch_pc[XLEN-1:2];
    assign bus.out_instr   = instr_q[rd_ptr];
    assign bus.out_pc      = pc_q[rd_ptr];
    assign bus.out_pcplus4 = pc_q[rd_ptr] + XLEN'(4);
    assign bus.q_count     = count;
    assign unused_pc_lsbs  = ^bus.redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(4);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count says they were written.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            instr_q[wr_ptr] <= bus.imem_rdata;
            pc_q[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: address-tagged memory model, one task per scenario.
`timescale 1ns/1ps
module tb_if_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    if_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    if_fetch_queue #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    // Synchronous memory: word returned the cycle after the enable.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= tag({bus.imem_addr, 2'b00});
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic start_run(input logic ready);
        rst_n = 1'b0;
        bus.redirect = 1'b0;
        bus.out_ready = ready;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        checks++; if (bus.imem_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_imem_en: got %0h want 0", bus.imem_en); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %0h want 0", bus.out_valid); end
        checks++; if (bus.q_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_q_count: got %0d want 0", bus.q_count); end
    endtask

    task automatic test_stream;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 30'h0) begin failures++; $display("[TB] FAIL stream_first_issue: got en=%0h addr=%0h want en=1 addr=0", bus.imem_en, bus.imem_addr); end
        tick; #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 30'h1) begin failures++; $display("[TB] FAIL stream_cycle2: got valid=%0h addr=%0h want valid=0 addr=1", bus.out_valid, bus.imem_addr); end
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(4 * i);
            tick; #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc) begin failures++; $display("[TB] FAIL stream_pc[%0d]: got valid=%0h pc=%h want valid=1 pc=%h", i, bus.out_valid, bus.out_pc, exp_pc); end
            checks++; if (bus.out_pcplus4 !== exp_pc + 32'd4 || bus.out_instr !== tag(exp_pc)) begin failures++; $display("[TB] FAIL stream_fields[%0d]: got pc4=%h instr=%h want pc4=%h instr=%h", i, bus.out_pcplus4, bus.out_instr, exp_pc + 32'd4, tag(exp_pc)); end
            checks++; if (bus.q_count !== 3'd1) begin failures++; $display("[TB] FAIL stream_count[%0d]: got %0d want 1", i, bus.q_count); end
        end
    endtask

    task automatic test_backpressure;
        start_run(1'b0);
        repeat (9) tick;
        #1;
        checks++; if (bus.q_count !== 3'd4 || bus.imem_en !== 1'b0) begin failures++; $display("[TB] FAIL bp_saturate: got count=%0d en=%0h want count=4 en=0", bus.q_count, bus.imem_en); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin failures++; $display("[TB] FAIL bp_head: got valid=%0h pc=%h want valid=1 pc=0", bus.out_valid, bus.out_pc); end
        tick;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_pc !== 32'h0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 30'h4) begin failures++; $display("[TB] FAIL bp_resume: got pc=%h en=%0h addr=%0h want pc=0 en=1 addr=4", bus.out_pc, bus.imem_en, bus.imem_addr); end
        for (int i = 1; i < 7; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(4 * i);
            tick; #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== tag(exp_pc)) begin failures++; $display("[TB] FAIL bp_drain[%0d]: got valid=%0h pc=%h instr=%h want pc=%h instr=%h", i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc, tag(exp_pc)); end
        end
    endtask

    task automatic test_redirect_full;
        start_run(1'b0);
        repeat (4) tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        #1;
        checks++; if (bus.q_count !== 3'd3 || bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0) begin failures++; $display("[TB] FAIL rdf_cycle: got count=%0d valid=%0h en=%0h want 3 0 0", bus.q_count, bus.out_valid, bus.imem_en); end
        tick;
        bus.redirect = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.q_count !== 3'd0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 30'h40 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdf_flush: got count=%0d en=%0h addr=%0h valid=%0h want 0 1 40 0", bus.q_count, bus.imem_en, bus.imem_addr, bus.out_valid); end
        tick; #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rdf_gap: got valid=%0h want 0", bus.out_valid); end
        tick; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_instr !== tag(32'h100)) begin failures++; $display("[TB] FAIL rdf_first: got valid=%0h pc=%h instr=%h want pc=100", bus.out_valid, bus.out_pc, bus.out_instr); end
        tick; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104) begin failures++; $display("[TB] FAIL rdf_second: got valid=%0h pc=%h want pc=104", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_redirect_align;
        tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        #1;
        checks++; if (bus.imem_en !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL align_cycle: got en=%0h valid=%0h want 0 0", bus.imem_en, bus.out_valid); end
        tick;
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 30'h80) begin failures++; $display("[TB] FAIL align_addr: got %0h want 80", bus.imem_addr); end
        tick; tick; #1;
        checks++; if (bus.out_pc !== 32'h200 || bus.out_pcplus4 !== 32'h204) begin failures++; $display("[TB] FAIL align_out: got pc=%h pc4=%h want 200 204", bus.out_pc, bus.out_pcplus4); end
    endtask

    task automatic test_redirect_held;
        start_run(1'b0);
        repeat (3) tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.q_count !== 3'd2 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL held_nopop: got count=%0d valid=%0h want 2 0", bus.q_count, bus.out_valid); end
        tick;
        bus.redirect_pc = 32'h0000_0080;
        #1;
        checks++; if (bus.q_count !== 3'd0 || bus.imem_en !== 1'b0) begin failures++; $display("[TB] FAIL held_cycle2: got count=%0d en=%0h want 0 0", bus.q_count, bus.imem_en); end
        tick;
        bus.redirect_pc = 32'h0000_00C0;
        #1;
        checks++; if (bus.imem_en !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL held_cycle3: got en=%0h valid=%0h want 0 0", bus.imem_en, bus.out_valid); end
        tick;
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 30'h30) begin failures++; $display("[TB] FAIL held_issue: got en=%0h addr=%0h want 1 30", bus.imem_en, bus.imem_addr); end
        tick; #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL held_gap: got valid=%0h want 0", bus.out_valid); end
        tick; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hC0) begin failures++; $display("[TB] FAIL held_first: got valid=%0h pc=%h want pc=c0", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_async_reset;
        tick; #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre: got valid=%0h want 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b0 || bus.q_count !== 3'd0) begin failures++; $display("[TB] FAIL areset_drop: got valid=%0h en=%0h count=%0d want 0 0 0", bus.out_valid, bus.imem_en, bus.q_count); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 30'h0 || bus.q_count !== 3'd0) begin failures++; $display("[TB] FAIL areset_restart: got en=%0h addr=%0h count=%0d want 1 0 0", bus.imem_en, bus.imem_addr, bus.q_count); end
        tick; tick; #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin failures++; $display("[TB] FAIL areset_first: got valid=%0h pc=%h want 1 0", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_wrap;
        tick;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        #1;
        tick;
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_addr !== 30'h3FFF_FFFF) begin failures++; $display("[TB] FAIL wrap_addr_top: got %0h want 3fffffff", bus.imem_addr); end
        tick; #1;
        checks++; if (bus.imem_en !== 1'b1 || bus.imem_addr !== 30'h0) begin failures++; $display("[TB] FAIL wrap_addr_zero: got en=%0h addr=%0h want 1 0", bus.imem_en, bus.imem_addr); end
        tick; #1;
        checks++; if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_pcplus4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_out_top: got pc=%h pc4=%h want fffffffc 0", bus.out_pc, bus.out_pcplus4); end
        tick; #1;
        checks++; if (bus.out_pc !== 32'h0 || bus.out_pcplus4 !== 32'h4) begin failures++; $display("[TB] FAIL wrap_out_zero: got pc=%h pc4=%h want 0 4", bus.out_pc, bus.out_pcplus4); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        $display("[TB] starting if_fetch_queue directed tests");
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_full;
        test_redirect_align;
        test_redirect_held;
        test_async_reset;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
